if_stage: RTL
=============

# if_stage

Instruction-fetch stage of the five-stage pipelined MIPS core. It owns the program counter and drives the instruction-memory address port. It captures the combinational instruction-memory output into the IF/ID pipeline register. It resolves PC redirects (branch, jump, jump-register), honours hazard-unit stall and flush requests, and keeps fetch and bubble performance counters.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded by reset.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `Stall`  in  1  hazard unit (load-use): hold the PC and IF/ID contents.
- `Flush`  in  1  load a bubble into IF/ID on this edge.
- `BranchTaken`  in  1  resolved taken branch.
- `BranchTarget`  in  32  branch target address.
- `JumpReg`  in  1  `jr` / `jalr` redirect.
- `JumpRegTarget`  in  32  register target address.
- `Jump`  in  1  `j` / `jal` redirect.
- `JumpTarget`  in  32  pseudo-direct target address.
- `PC`  out  32  current PC; drives the instruction-memory `Address`.
- `Instruction`  in  32  combinational instruction-memory read data for `PC`.
- `IF_ID_PC`  out  32  PC of the instruction held in IF/ID.
- `IF_ID_PCPlus4`  out  32  that PC + 4.
- `IF_ID_Instruction`  out  32  instruction held in IF/ID.
- `IF_ID_Valid`  out  1  1 = real instruction, 0 = bubble.
- `FetchCount`  out  CNT_W  valid instructions loaded into IF/ID.
- `BubbleCount`  out  CNT_W  bubbles loaded into IF/ID because of `Flush`.

## Operation
- Next-PC priority: `BranchTaken` > `JumpReg` > `Jump` > `Stall` (hold) > `PC + 4`.
- A redirect always updates the PC, even when `Stall` is high. Redirects come from older instructions than a load-use stall.
- Every target is word-aligned by forcing bits [1:0] to 00. The misalignment is not reported.
- `PC + 4` is 32-bit modular: 32'hFFFF_FFFC wraps to 32'h0000_0000.
- IF/ID update on each edge:
  - `Flush` = 1: Instruction = 32'h0000_0000 (NOP), Valid = 0, PC fields = current `PC`. `BubbleCount` += 1.
  - Else `Stall` = 1: all IF/ID fields hold.
  - Else: load `PC`, `PC + 4`, `Instruction`, and Valid = 1. `FetchCount` += 1.
- `Flush` overrides `Stall` for IF/ID. `Stall` never blocks a flush.
- The counters saturate at all-ones and do not wrap.
- States (implicit in Valid):
  - RUN: Valid = 1.
  - BUBBLE: Valid = 0.
  - BUBBLE → RUN on the first edge with `Flush` = 0 and `Stall` = 0.
  - Any state → BUBBLE on `Flush`.
  - `Stall` keeps the current state.

## Timing
- Reset (asynchronous, immediate):
  - `PC` = RESET_PC.
  - `IF_ID_PC`, `IF_ID_PCPlus4`, `IF_ID_Instruction` = 0.
  - `IF_ID_Valid` = 0.
  - Both counters = 0.
- First rising edge after `reset_n` deasserts: IF/ID captures the instruction at RESET_PC and `PC` becomes RESET_PC + 4.
- `PC` to `Instruction` is combinational, within the same cycle.
- Fetch-to-ID latency is 1 cycle.
- Redirect asserted in cycle N: `PC` = target after edge N. The instruction already in IF/ID is killed only if the hazard unit asserts `Flush` in cycle N. This block never flushes on its own.
- Reset asserted mid-operation (including during `Stall` or `Flush`): all state returns to reset values asynchronously. No partial update survives.
- Inputs are sampled only at the rising edge. Glitches between edges have no effect.

## Structure
- Shared package `cpu_pkg` holds:
  - `NOP_INSTR` = 32'h0000_0000.
  - Default `RESET_PC`.
  - `pc_sel_t` enum: SEQ, HOLD, BRANCH, JREG, JUMP.
- One sub-module, `pc_next_sel`: purely combinational priority select. It produces `pc_sel_t` and the aligned next PC.
- The PC register, IF/ID register, and saturating counters live in `if_stage`.

## Test plan
- **Reset:** hold `reset_n` = 0, then release. Memory returns 32'h241D0100 at PC 0. After edge 1: `IF_ID_Instruction` = 32'h241D0100, `IF_ID_PC` = 0, Valid = 1, `PC` = 4, `FetchCount` = 1.
- **Stall:** `Stall` = 1 for 3 cycles at `PC` = 0x14. `PC` stays 0x14, IF/ID is unchanged, `FetchCount` is unchanged. On release, IF/ID = {0x14, 0x18}.
- **Branch plus flush:** at `PC` = 0x20, assert `BranchTaken` with `BranchTarget` = 0x100 and `Flush` together. Next edge: `PC` = 0x100, Valid = 0, `IF_ID_Instruction` = 0, `BubbleCount` = 1.
- **Simultaneous redirects:** `BranchTaken` (0x40), `JumpReg` (0x80), `Jump` (0xC0), and `Stall` all asserted. `PC` = 0x40. With `JumpRegTarget` = 0x83 alone, `PC` = 0x80.
- **Wrap:** force `PC` to 0xFFFF_FFFC via a jump. One edge later `PC` = 0x0000_0000 and `IF_ID_PCPlus4` = 0.
- **Mid-flush reset:** assert `reset_n` = 0 asynchronously during a `Flush` cycle. `PC` = RESET_PC immediately and counters = 0, with no dependence on a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants, PC-select encoding and target alignment for the MIPS core.
package cpu_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef enum logic [2:0] {SEQ, HOLD, BRANCH, JREG, JUMP} pc_sel_t;
  function automatic logic [31:0] align(input logic [31:0] a);
    return a & ~32'd3;
  endfunction
endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: priority select of the next PC; redirects beat a load-use stall.
module pc_next_sel
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_reg,
  input  logic [31:0] jump_reg_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output pc_sel_t     sel,
  output logic [31:0] pc_next
);
  always_comb begin
    sel = branch_taken ? BRANCH : jump_reg ? JREG : jump ? JUMP : stall ? HOLD : SEQ;
    pc_next = sel == BRANCH ? align(branch_target) :
              sel == JREG   ? align(jump_reg_target) :
              sel == JUMP   ? align(jump_target) :
              sel == HOLD   ? pc : pc + 32'd4;
  end
endmodule

// File: rtl/if_stage.sv
// if_stage: owns the PC, fills the IF/ID register and counts fetches and flush bubbles.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             Stall,
  input  logic             Flush,
  input  logic             BranchTaken,
  input  logic [31:0]      BranchTarget,
  input  logic             JumpReg,
  input  logic [31:0]      JumpRegTarget,
  input  logic             Jump,
  input  logic [31:0]      JumpTarget,
  output logic [31:0]      PC,
  input  logic [31:0]      Instruction,
  output logic [31:0]      IF_ID_PC,
  output logic [31:0]      IF_ID_PCPlus4,
  output logic [31:0]      IF_ID_Instruction,
  output logic             IF_ID_Valid,
  output logic [CNT_W-1:0] FetchCount,
  output logic [CNT_W-1:0] BubbleCount
);
  pc_sel_t     sel;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  assign pc_plus4 = PC + 32'd4;
  pc_next_sel u_sel (
    .pc              (PC),
    .stall           (Stall),
    .branch_taken    (BranchTaken),
    .branch_target   (BranchTarget),
    .jump_reg        (JumpReg),
    .jump_reg_target (JumpRegTarget),
    .jump            (Jump),
    .jump_target     (JumpTarget),
    .sel             (sel),
    .pc_next         (pc_next)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) PC <= RESET_PC;
    else if (sel != HOLD) PC <= pc_next;
  end
  // A flush wins over a stall so a killed instruction can never linger in IF/ID.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      IF_ID_PC          <= '0;
      IF_ID_PCPlus4     <= '0;
      IF_ID_Instruction <= '0;
      IF_ID_Valid       <= 1'b0;
      FetchCount        <= '0;
      BubbleCount       <= '0;
    end else if (Flush) begin
      IF_ID_PC          <= PC;
      IF_ID_PCPlus4     <= pc_plus4;
      IF_ID_Instruction <= NOP_INSTR;
      IF_ID_Valid       <= 1'b0;
      BubbleCount       <= &BubbleCount ? BubbleCount : BubbleCount + 1'b1;
    end else if (!Stall) begin
      IF_ID_PC          <= PC;
      IF_ID_PCPlus4     <= pc_plus4;
      IF_ID_Instruction <= Instruction;
      IF_ID_Valid       <= 1'b1;
      FetchCount        <= &FetchCount ? FetchCount : FetchCount + 1'b1;
    end
  end
endmodule
